// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_pkg;

   localparam int MEM_ADDR_W = 15;
   localparam int MEM_DATA_W = 32;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   // Width of a counter that must hold 0..max_val inclusive
   function automatic int cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_prio.sv
// CPU-first arbitration with a saturating starve counter that
// guarantees DMA a slot after STARVE_MAX back-to-back CPU wins.
module arb_prio
   import mem_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic cpu_req,
   input  logic dma_elig,
   output logic grant_valid,
   output logic grant_dma
);

   localparam int SCW = cnt_width(STARVE_MAX);
   localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

   logic [SCW-1:0] starve_q;
   logic [SCW-1:0] starve_d;
   logic           starved;

   // Winner selection: CPU by default, DMA when alone or starved
   always_comb begin
      starved     = (starve_q == STARVE_LIM);
      grant_valid = cpu_req | dma_elig;
      grant_dma   = dma_elig & (~cpu_req | starved);
   end

   // Starve counter next value, only evaluated while the arbiter is idle
   always_comb begin
      starve_d = starve_q;
      if (arb_en) begin
         if (!dma_elig) begin
            starve_d = '0;
         end else if (grant_dma) begin
            starve_d = '0;
         end else if (!starved) begin
            starve_d = starve_q + SCW'(1);
         end
      end
   end

   // Starve counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU, DMA) arbiter in front of a single-port memory
// controller. One transfer at a time, strobe/ready handshake to memory,
// one-cycle ack pulse back to the owning master.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; latch winner's command when any request present
// ST_ISSUE | one-cycle mem_start (read) or mem_w (write) strobe
// ST_WAIT  | wait for matching ready, bounded by TIMEOUT cycles
// ST_ACK   | one-cycle ack to owner, requests ignored
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_w,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_w,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   input  logic              dma_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_w,
   output logic              mem_start,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_readrdy,
   input  logic              mem_saverdy,
   output logic              busy,
   output logic              owner,
   output logic              timeout_err
);

   // WAIT may last at most TIMEOUT cycles; the counter runs 0..TIMEOUT-1
   localparam int TCW = cnt_width(TIMEOUT);
   localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TCW-1:0] TO_LAST = TCW'(TO_LAST_I);

   state_e            state_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_w_q;
   logic              mem_start_q;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              busy_q;
   logic              owner_q;
   logic              timeout_err_q;
   logic              cur_w_q;
   logic [TCW-1:0]    wait_cnt_q;

   logic              dma_elig;
   logic              arb_en;
   logic              grant_valid;
   logic              grant_dma;
   logic              win_w;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              rdy_match;
   logic              wait_expired;
   logic [DATA_W-1:0] fill_data;

   arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb_prio (
      .clk         (clk),
      .rst         (rst),
      .arb_en      (arb_en),
      .cpu_req     (cpu_req),
      .dma_elig    (dma_elig),
      .grant_valid (grant_valid),
      .grant_dma   (grant_dma)
   );

   // Winner command mux and WAIT-state completion decode
   always_comb begin
      dma_elig     = dma_req & dma_en;
      arb_en       = (state_q == ST_IDLE);
      win_w        = grant_dma ? dma_w     : cpu_w;
      win_addr     = grant_dma ? dma_addr  : cpu_addr;
      win_wdata    = grant_dma ? dma_wdata : cpu_wdata;
      // Only the ready matching the latched direction counts
      rdy_match    = cur_w_q ? mem_saverdy : mem_readrdy;
      wait_expired = (wait_cnt_q == TO_LAST);
      // A timed-out read returns zero rather than whatever is on the bus
      fill_data    = rdy_match ? mem_rdata : '0;
   end

   // Transfer sequencer with registered strobes, acks and status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_w_q       <= 1'b0;
         mem_start_q   <= 1'b0;
         cpu_ack_q     <= 1'b0;
         dma_ack_q     <= 1'b0;
         cpu_rdata_q   <= '0;
         dma_rdata_q   <= '0;
         busy_q        <= 1'b0;
         owner_q       <= OWNER_CPU;
         timeout_err_q <= 1'b0;
         cur_w_q       <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         mem_w_q     <= 1'b0;
         mem_start_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  mem_addr_q  <= win_addr;
                  mem_wdata_q <= win_wdata;
                  cur_w_q     <= win_w;
                  owner_q     <= grant_dma ? OWNER_DMA : OWNER_CPU;
                  mem_w_q     <= win_w;
                  mem_start_q <= ~win_w;
                  busy_q      <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Readies during the strobe cycle are deliberately not looked at
               wait_cnt_q <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (rdy_match || wait_expired) begin
                  if (!rdy_match) begin
                     timeout_err_q <= 1'b1;
                  end
                  if (!cur_w_q) begin
                     if (owner_q == OWNER_DMA) begin
                        dma_rdata_q <= fill_data;
                     end else begin
                        cpu_rdata_q <= fill_data;
                     end
                  end
                  if (owner_q == OWNER_DMA) begin
                     dma_ack_q <= 1'b1;
                  end else begin
                     cpu_ack_q <= 1'b1;
                  end
                  state_q <= ST_ACK;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TCW'(1);
               end
            end
            ST_ACK: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_w       = mem_w_q;
   assign mem_start   = mem_start_q;
   assign cpu_ack     = cpu_ack_q;
   assign dma_ack     = dma_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign dma_rdata   = dma_rdata_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-timeline model predicts every
// output each cycle; scenario code adds hand-computed literal checks.
module tb_mem_arbiter;

   localparam int ADDR_W     = 15;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0, cpu_w = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dma_req = 1'b0, dma_w = 1'b0, dma_en = 1'b0;
   logic [ADDR_W-1:0] dma_addr = '0;
   logic [DATA_W-1:0] dma_wdata = '0;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_w, mem_start;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_readrdy = 1'b0, mem_saverdy = 1'b0;
   logic              busy, owner, timeout_err;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_w(cpu_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_w(dma_w), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_en(dma_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_start(mem_start),
      .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy),
      .busy(busy), .owner(owner), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- memory responder ----------------
   int                rsp_delay = 1;   // cycles from strobe to ready; 0 = never
   bit                rsp_noise = 1'b0;
   logic [DATA_W-1:0] rsp_data = '0;
   int                rsp_at = -1;
   bit                rsp_w = 1'b0;

   always begin
      @(posedge clk);
      #1;
      mem_readrdy = 1'b0;
      mem_saverdy = 1'b0;
      mem_rdata   = ~rsp_data;
      if (mem_start || mem_w) begin
         rsp_w  = mem_w;
         rsp_at = (rsp_delay > 0) ? cyc + rsp_delay : -1;
         if (rsp_noise) begin
            mem_readrdy = 1'b1;
            mem_saverdy = 1'b1;
         end
      end else if (rsp_noise && rsp_at > cyc) begin
         if (rsp_w) mem_readrdy = 1'b1;
         else       mem_saverdy = 1'b1;
      end
      if (cyc == rsp_at) begin
         if (rsp_w) mem_saverdy = 1'b1;
         else       mem_readrdy = 1'b1;
         mem_rdata = rsp_data;
      end
   end

   // ---------------- grant log from DUT strobes ----------------
   string grant_str = "";
   int    last_strobe = -1;
   int    wcount = 0;
   always @(negedge clk) begin
      string g;
      if (chk_en && (mem_start || mem_w)) begin
         g = owner ? "D" : "C";
         grant_str = {grant_str, g};
         last_strobe = cyc;
         if (mem_w) wcount++;
      end
   end

   // ---------------- timeline model + per-cycle compare ----------------
   logic              exp_busy = 0, exp_owner = 0, exp_to = 0;
   logic              exp_start = 0, exp_mw = 0, exp_cack = 0, exp_dack = 0;
   logic [DATA_W-1:0] exp_crd = '0, exp_drd = '0, exp_wdata = '0;
   logic [ADDR_W-1:0] exp_addr = '0;
   int                m_g = -1;       // cycle in which the current grant was decided
   int                m_ack_at = -1;  // cycle in which the ack is visible
   bit                m_w = 0, m_dma = 0, m_elig = 0, m_rdy = 0;
   int                m_starve = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, exp_busy);
         chk("owner", owner, exp_owner);
         chk("timeout_err", timeout_err, exp_to);
         chk("mem_start", mem_start, exp_start);
         chk("mem_w", mem_w, exp_mw);
         chk("cpu_ack", cpu_ack, exp_cack);
         chk("dma_ack", dma_ack, exp_dack);
         chk("cpu_rdata", cpu_rdata, exp_crd);
         chk("dma_rdata", dma_rdata, exp_drd);
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_wdata", mem_wdata, exp_wdata);
      end
      exp_start = 0; exp_mw = 0; exp_cack = 0; exp_dack = 0;
      if (rst) begin
         exp_busy = 0; exp_owner = 0; exp_to = 0;
         exp_crd = '0; exp_drd = '0; exp_addr = '0; exp_wdata = '0;
         m_g = -1; m_ack_at = -1; m_starve = 0;
      end else if (m_g < 0) begin
         m_elig = dma_req && dma_en;
         if (!m_elig) m_starve = 0;
         if (cpu_req || m_elig) begin
            m_dma = m_elig && (!cpu_req || m_starve == STARVE_MAX);
            if (m_dma) m_starve = 0;
            else if (m_elig) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            m_w       = m_dma ? dma_w : cpu_w;
            exp_addr  = m_dma ? dma_addr : cpu_addr;
            exp_wdata = m_dma ? dma_wdata : cpu_wdata;
            exp_owner = m_dma;
            exp_start = !m_w;
            exp_mw    = m_w;
            exp_busy  = 1;
            m_g = cyc;
            m_ack_at = -1;
         end
      end else if (cyc == m_ack_at) begin
         exp_busy = 0;
         m_g = -1;
      end else if (cyc >= m_g + 2 && m_ack_at < 0) begin
         m_rdy = m_w ? mem_saverdy : mem_readrdy;
         if (m_rdy || (cyc - m_g - 1) == TIMEOUT) begin
            if (!m_rdy) exp_to = 1;
            if (!m_w) begin
               if (m_dma) exp_drd = m_rdy ? mem_rdata : '0;
               else       exp_crd = m_rdy ? mem_rdata : '0;
            end
            if (m_dma) exp_dack = 1;
            else       exp_cack = 1;
            m_ack_at = cyc + 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_req(input bit is_dma, input bit w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int delay, input bit noise,
                            input logic [DATA_W-1:0] rd, output int n);
      @(posedge clk); #1;
      rsp_delay = delay; rsp_noise = noise; rsp_data = rd;
      if (is_dma) begin dma_req = 1; dma_w = w; dma_addr = a; dma_wdata = d; end
      else        begin cpu_req = 1; cpu_w = w; cpu_addr = a; cpu_wdata = d; end
      n = cyc;
   endtask

   task automatic wait_ack(input bit is_dma, output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (is_dma ? dma_ack : cpu_ack) begin
            at = cyc;
            break;
         end
      end
      chk("ack_seen", (at >= 0), 1);
   endtask

   task automatic drop_req(input bit is_dma);
      @(posedge clk); #1;
      if (is_dma) dma_req = 0;
      else        cpu_req = 0;
   endtask

   task automatic txn(input bit is_dma, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input int delay, input bit noise,
                      input logic [DATA_W-1:0] rd, output int n, output int at);
      start_req(is_dma, w, a, d, delay, noise, rd, n);
      wait_ack(is_dma, at);
      drop_req(is_dma);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int n, a, w0, glen, nack;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1;
      rst = 0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_timeout", timeout_err, 0);

      // CPU read, ready one cycle after strobe
      txn(0, 0, 15'h0123, 0, 1, 0, 32'hDEADBEEF, n, a);
      chk("r23_latency", a - n, 3);
      chk("r23_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("r23_dma_rdata", dma_rdata, 0);

      // DMA write with stray readies in ISSUE and WAIT
      dma_en = 1;
      w0 = wcount;
      txn(1, 1, 15'h1800, 32'h12345678, 2, 1, 32'h0, n, a);
      chk("r24_wpulses", wcount - w0, 1);
      chk("r24_addr", mem_addr, 15'h1800);
      chk("r24_wdata", mem_wdata, 32'h12345678);
      chk("r24_owner", owner, 1);
      chk("r24_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

      // CPU write, DMA read, CPU read with stray readies
      txn(0, 1, 15'h0042, 32'hA5A50F0F, 3, 1, 32'h0, n, a);
      txn(1, 0, 15'h7FFF, 0, 1, 0, 32'hCAFEF00D, n, a);
      chk("dma_rd", dma_rdata, 32'hCAFEF00D);
      chk("dma_rd_cpu_kept", cpu_rdata, 32'hDEADBEEF);
      txn(0, 0, 15'h0100, 0, 3, 1, 32'h0BADC0DE, n, a);
      chk("noise_rdata", cpu_rdata, 32'h0BADC0DE);
      chk("noise_latency", a - n, 5);

      // Both requesters held continuously: starvation bound
      repeat (2) @(posedge clk);
      #1;
      rsp_delay = 1; rsp_noise = 0; rsp_data = 32'h11110000;
      grant_str = "";
      cpu_req = 1; cpu_w = 0; cpu_addr = 15'h0010;
      dma_req = 1; dma_w = 0; dma_addr = 15'h0020; dma_en = 1;
      for (int i = 0; i < 300 && grant_str.len() < 10; i++) @(negedge clk);
      @(posedge clk); #1;
      cpu_req = 0; dma_req = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      checks++;
      if (grant_str != "CCCCDCCCCD") begin
         errors++;
         $display("FAIL r25_order: got %s, required CCCCDCCCCD", grant_str);
      end

      // DMA request gated by dma_en
      @(posedge clk); #1;
      dma_en = 0; dma_req = 1; dma_w = 0; dma_addr = 15'h0033; rsp_data = 32'h5555AAAA;
      glen = grant_str.len();
      repeat (6) @(posedge clk);
      #1;
      chk("r26_no_grant", grant_str.len() - glen, 0);
      chk("r26_idle", busy, 0);
      dma_en = 1;
      n = cyc;
      wait_ack(1, a);
      drop_req(1);
      chk("r26_latency", a - n, 3);
      chk("r26_owner", owner, 1);
      chk("r26_dma_rdata", dma_rdata, 32'h5555AAAA);

      // Dropping dma_req/dma_en mid-transfer does not abort it
      start_req(1, 0, 15'h0044, 0, 4, 0, 32'h77778888, n);
      repeat (2) @(posedge clk);
      #1;
      dma_req = 0; dma_en = 0;
      wait_ack(1, a);
      chk("r14_latency", a - n, 6);
      chk("r14_rdata", dma_rdata, 32'h77778888);

      // Read that never gets a ready
      txn(0, 0, 15'h0055, 0, 0, 0, 32'h0, n, a);
      chk("r27_flag", timeout_err, 1);
      chk("r27_rdata", cpu_rdata, 0);
      chk("r27_wait_len", a - last_strobe, TIMEOUT + 1);
      txn(0, 1, 15'h0056, 32'h99, 1, 0, 32'h0, n, a);
      chk("r27_sticky", timeout_err, 1);
      chk("r27_good_latency", a - n, 3);

      // Reset while waiting; late ready must not produce an ack
      start_req(0, 0, 15'h0077, 0, 5, 0, 32'hFEEDFACE, n);
      repeat (3) @(posedge clk);
      #1;
      rst = 1; cpu_req = 0;
      @(posedge clk); #1;
      rst = 0;
      nack = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cpu_ack || dma_ack) nack++;
      end
      chk("r28_no_ack", nack, 0);
      chk("r28_cpu_rdata", cpu_rdata, 0);
      chk("r28_timeout", timeout_err, 0);
      chk("r28_addr", mem_addr, 0);
      chk("r28_busy", busy, 0);
      txn(0, 0, 15'h0078, 0, 1, 0, 32'h600DF00D, n, a);
      chk("r28_after_rdata", cpu_rdata, 32'h600DF00D);
      chk("r28_after_latency", a - n, 3);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
